// File: rtl/stage_sequencer_pkg.sv
// Shared types and constants for the per-node stage sequencer.
package stage_sequencer_pkg;

  localparam int unsigned WDOG_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SELECT = 3'd1,
    ST_LAUNCH = 3'd2,
    ST_RUN    = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

  localparam logic [1:0] STATUS_COMPLETE = 2'b00;
  localparam logic [1:0] STATUS_ABORT    = 2'b01;
  localparam logic [1:0] STATUS_TIMEOUT  = 2'b10;

  localparam int unsigned STAGE_AMISINK         = 0;
  localparam int unsigned STAGE_FORWARDING      = 1;
  localparam int unsigned STAGE_FIXSINKLIST     = 2;
  localparam int unsigned STAGE_NEIGHBORCLUSTER = 3;
  localparam int unsigned STAGE_BEST            = 4;
  localparam int unsigned STAGE_BETTERNEIGHBOR  = 5;
  localparam int unsigned STAGE_POLICY          = 6;
  localparam int unsigned STAGE_SELECTACTION    = 7;

  // Memory address map: each stage owns a 4-word region.
  localparam logic [15:0] ADDR_BASE_AMISINK         = 16'h0000;
  localparam logic [15:0] ADDR_BASE_FORWARDING      = 16'h0004;
  localparam logic [15:0] ADDR_BASE_FIXSINKLIST     = 16'h0008;
  localparam logic [15:0] ADDR_BASE_NEIGHBORCLUSTER = 16'h000C;
  localparam logic [15:0] ADDR_BASE_BEST            = 16'h0010;
  localparam logic [15:0] ADDR_BASE_BETTERNEIGHBOR  = 16'h0014;
  localparam logic [15:0] ADDR_BASE_POLICY          = 16'h0018;
  localparam logic [15:0] ADDR_BASE_SELECTACTION    = 16'h001C;

endpackage

// File: rtl/stage_sequencer_if.sv
// Stage handshake and shared memory port bundle of the stage sequencer.
interface stage_sequencer_if #(
  parameter int unsigned NUM_STAGES = 8,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
);
  logic                             start;
  logic [NUM_STAGES-1:0]            stage_mask;
  logic [NUM_STAGES-1:0]            stage_done;
  logic [NUM_STAGES-1:0]            stage_abort;
  logic [NUM_STAGES*WORD_WIDTH-1:0] stage_addr;
  logic [NUM_STAGES-1:0]            stage_wr_en;
  logic [NUM_STAGES-1:0]            stage_go;
  logic [NUM_STAGES-1:0]            stage_clr_n;
  logic [WORD_WIDTH-1:0]            mem_addr;
  logic                             mem_wr_en;
  logic                             busy;
  logic                             round_done;
  logic [1:0]                       round_status;
  logic [IDX_W-1:0]                 last_stage;

  // Sequencer side.
  modport master (
    input  start, stage_mask, stage_done, stage_abort, stage_addr, stage_wr_en,
    output stage_go, stage_clr_n, mem_addr, mem_wr_en, busy, round_done,
           round_status, last_stage
  );

  // Stage / environment side.
  modport slave (
    output start, stage_mask, stage_done, stage_abort, stage_addr, stage_wr_en,
    input  stage_go, stage_clr_n, mem_addr, mem_wr_en, busy, round_done,
           round_status, last_stage
  );
endinterface

// File: rtl/stage_sequencer_addr_wr_mux.sv
// Selects the active stage's address and write request onto the shared port.
module stage_sequencer_addr_wr_mux #(
  parameter int unsigned NUM_STAGES = 8,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned IDX_W      = $clog2(NUM_STAGES)
) (
  input  logic [IDX_W-1:0]                 idx_i,
  input  logic                             run_i,
  input  logic [NUM_STAGES*WORD_WIDTH-1:0] stage_addr_i,
  input  logic [NUM_STAGES-1:0]            stage_wr_en_i,
  output logic [WORD_WIDTH-1:0]            addr_o,
  output logic                             wr_en_o
);

  logic wr_sel;

  // Index-driven select; writes only pass while the stage is actually running.
  always_comb begin
    addr_o = '0;
    wr_sel = 1'b0;
    for (int unsigned k = 0; k < NUM_STAGES; k++) begin
      if (idx_i == IDX_W'(k)) begin
        addr_o = stage_addr_i[k*WORD_WIDTH +: WORD_WIDTH];
        wr_sel = stage_wr_en_i[k];
      end
    end
    wr_en_o = run_i & wr_sel;
  end

endmodule

// File: rtl/stage_sequencer.sv
// Registered round sequencer: launches enabled stages in order over one memory port.
module stage_sequencer
  import stage_sequencer_pkg::*;
#(
  parameter int unsigned NUM_STAGES = 8,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic clock,
  input  logic nrst,
  stage_sequencer_if.master bus
);

  localparam int unsigned IDX_W = $clog2(NUM_STAGES);

  state_e                state_q;
  logic [IDX_W-1:0]      idx_q;
  logic [WDOG_W-1:0]     wdog_q;
  logic [NUM_STAGES-1:0] go_q;
  logic [NUM_STAGES-1:0] clr_n_q;
  logic                  busy_q;
  logic                  round_done_q;
  logic [1:0]            status_q;
  logic [IDX_W-1:0]      last_q;

  logic                  idx_last;
  logic                  wdog_expired;
  logic                  run;
  logic [WORD_WIDTH-1:0] mux_addr;
  logic                  mux_wr_en;

  assign idx_last     = (idx_q == IDX_W'(NUM_STAGES - 1));
  assign wdog_expired = (wdog_q == WDOG_W'(TIMEOUT - 1));
  assign run          = (state_q == ST_RUN);

  // Outputs are registered alongside the state they belong to, so each one
  // is set on the transition into its state rather than decoded afterwards.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q      <= ST_IDLE;
      idx_q        <= '0;
      wdog_q       <= '0;
      go_q         <= '0;
      clr_n_q      <= '1;
      busy_q       <= 1'b0;
      round_done_q <= 1'b0;
      status_q     <= STATUS_COMPLETE;
      last_q       <= '0;
    end else begin
      go_q         <= '0;
      clr_n_q      <= '1;
      round_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            idx_q   <= '0;
            state_q <= ST_SELECT;
            busy_q  <= 1'b1;
          end
        end
        ST_SELECT: begin
          if (bus.stage_mask[idx_q]) begin
            state_q        <= ST_LAUNCH;
            clr_n_q[idx_q] <= 1'b0;
          end else if (idx_last) begin
            state_q      <= ST_FINISH;
            round_done_q <= 1'b1;
            status_q     <= STATUS_COMPLETE;
            last_q       <= idx_q;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        ST_LAUNCH: begin
          wdog_q      <= '0;
          state_q     <= ST_RUN;
          go_q[idx_q] <= 1'b1;
        end
        ST_RUN: begin
          wdog_q <= wdog_q + WDOG_W'(1);
          // done takes priority over a watchdog expiry in the same cycle
          if (bus.stage_done[idx_q]) begin
            if (bus.stage_abort[idx_q]) begin
              state_q      <= ST_FINISH;
              round_done_q <= 1'b1;
              status_q     <= STATUS_ABORT;
              last_q       <= idx_q;
            end else if (idx_last) begin
              state_q      <= ST_FINISH;
              round_done_q <= 1'b1;
              status_q     <= STATUS_COMPLETE;
              last_q       <= idx_q;
            end else begin
              idx_q   <= idx_q + IDX_W'(1);
              state_q <= ST_SELECT;
            end
          end else if (wdog_expired) begin
            state_q      <= ST_FINISH;
            round_done_q <= 1'b1;
            status_q     <= STATUS_TIMEOUT;
            last_q       <= idx_q;
          end else begin
            go_q[idx_q] <= 1'b1;
          end
        end
        ST_FINISH: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  stage_sequencer_addr_wr_mux #(
    .NUM_STAGES (NUM_STAGES),
    .WORD_WIDTH (WORD_WIDTH),
    .IDX_W      (IDX_W)
  ) u_addr_wr_mux (
    .idx_i         (idx_q),
    .run_i         (run),
    .stage_addr_i  (bus.stage_addr),
    .stage_wr_en_i (bus.stage_wr_en),
    .addr_o        (mux_addr),
    .wr_en_o       (mux_wr_en)
  );

  assign bus.stage_go     = go_q;
  assign bus.stage_clr_n  = clr_n_q;
  assign bus.mem_addr     = mux_addr;
  assign bus.mem_wr_en    = mux_wr_en;
  assign bus.busy         = busy_q;
  assign bus.round_done   = round_done_q;
  assign bus.round_status = status_q;
  assign bus.last_stage   = last_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed scoreboard bench for stage_sequencer.
module tb_stage_sequencer;
  import stage_sequencer_pkg::*;

  localparam int unsigned NS = 8;
  localparam int unsigned WW = 16;
  localparam int unsigned TO = 16;

  logic clk  = 1'b0;
  logic nrst = 1'b0;
  always #5 clk = ~clk;

  stage_sequencer_if #(.NUM_STAGES(NS), .WORD_WIDTH(WW)) bif();

  stage_sequencer #(.NUM_STAGES(NS), .WORD_WIDTH(WW), .TIMEOUT(TO)) dut (
    .clock (clk),
    .nrst  (nrst),
    .bus   (bif)
  );

  int unsigned nchk  = 0;
  int unsigned npass = 0;
  int unsigned nfail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Stage models: done rises dly cycles of go after launch, held until cleared.
  int unsigned     dly[NS];
  int unsigned     cnt[NS];
  logic [NS-1:0]   done_r;
  logic [NS-1:0]   abort_cfg;
  assign bif.stage_done  = done_r;
  assign bif.stage_abort = abort_cfg & done_r;

  always @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      done_r <= '0;
      for (int k = 0; k < NS; k++) cnt[k] <= 0;
    end else begin
      for (int k = 0; k < NS; k++) begin
        if (!bif.stage_clr_n[k]) begin
          cnt[k]    <= 0;
          done_r[k] <= 1'b0;
        end else if (bif.stage_go[k]) begin
          cnt[k] <= cnt[k] + 1;
          if (cnt[k] + 1 >= dly[k]) done_r[k] <= 1'b1;
        end
      end
    end
  end

  // Cycle counter and memory write log.
  int unsigned cyc = 0;
  int unsigned wcnt[32];
  int unsigned wtotal = 0;
  always @(posedge clk) begin
    cyc++;
    if (bif.mem_wr_en) begin
      wcnt[bif.mem_addr[4:0]]++;
      wtotal++;
    end
  end

  // Scoreboard queues.
  int unsigned exp_launch[$];
  logic [4:0]  exp_round[$];

  // Monitor, sampled on the falling edge.
  logic [NS-1:0] prev_go = '0;
  int unsigned   launch_cyc[NS];
  int unsigned   fall_cyc[NS];
  int unsigned   go_len[NS];
  int unsigned   rounds_seen = 0;
  int unsigned   last_rd_cyc = 0;
  int unsigned   clr_pulses = 0;
  int            li;

  always @(negedge clk) begin
    if (nrst) begin
      li = -1;
      for (int k = 0; k < NS; k++) begin
        if (bif.stage_go[k]) begin
          li = k;
          if (!prev_go[k]) begin
            launch_cyc[k] = cyc;
            go_len[k] = 0;
          end
          go_len[k]++;
        end else if (prev_go[k]) begin
          fall_cyc[k] = cyc;
        end
        if (!bif.stage_clr_n[k]) clr_pulses++;
      end
      if (bif.stage_go != '0) begin
        check("run_addr", 32'(bif.mem_addr), 32'(li * 4));
        if ((bif.stage_go & ~prev_go) != '0) begin
          check("go_onehot", 32'($onehot(bif.stage_go)), 32'd1);
          check("busy_in_run", 32'(bif.busy), 32'd1);
          if (exp_launch.size() == 0) check("unexpected_launch", 32'(li), 32'hFFFF_FFFF);
          else check("launch_idx", 32'(li), exp_launch.pop_front());
        end
      end
      if (bif.mem_wr_en) begin
        check("wr_addr", 32'(bif.mem_addr), 32'(ADDR_BASE_FORWARDING));
        check("wr_only_stage1", 32'(bif.stage_go), 32'h2);
      end
      if (bif.round_done) begin
        if (exp_round.size() == 0)
          check("unexpected_round", 32'({bif.round_status, bif.last_stage}), 32'hFFFF_FFFF);
        else
          check("round_result", 32'({bif.round_status, bif.last_stage}), 32'(exp_round.pop_front()));
        rounds_seen++;
        last_rd_cyc = cyc;
      end
      prev_go = bif.stage_go;
    end else begin
      prev_go = '0;
    end
  end

  int unsigned start_cyc;
  int unsigned clr0;

  task automatic wait_rounds(input int unsigned target, input int unsigned budget, input string tag);
    int unsigned i = 0;
    while (rounds_seen < target && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check(tag, 32'(rounds_seen >= target), 32'd1);
  endtask

  task automatic push_round(input logic [NS-1:0] mask, input logic [1:0] st,
                            input int unsigned last, input int unsigned stop);
    for (int k = 0; k < NS; k++) begin
      if (mask[k]) exp_launch.push_back(k);
      if (k == int'(stop)) break;
    end
    exp_round.push_back({st, 3'(last)});
  endtask

  task automatic run_round(input logic [NS-1:0] mask, input logic [1:0] st,
                           input int unsigned last, input int unsigned stop, input string tag);
    int unsigned tgt;
    bif.stage_mask = mask;
    push_round(mask, st, last, stop);
    clr0 = clr_pulses;
    tgt = rounds_seen + 1;
    bif.start = 1'b1;
    start_cyc = cyc;
    @(posedge clk); #1;
    bif.start = 1'b0;
    wait_rounds(tgt, 300, tag);
    check({tag, "_launch_q_empty"}, 32'(exp_launch.size()), 32'd0);
    check({tag, "_round_q_empty"}, 32'(exp_round.size()), 32'd0);
  endtask

  initial begin
    int unsigned wb;
    int unsigned rd1;
    int unsigned base;
    int unsigned i;

    bif.start       = 1'b0;
    bif.stage_mask  = '0;
    bif.stage_wr_en = '0;
    abort_cfg       = '0;
    for (int k = 0; k < NS; k++) begin
      dly[k] = 5;
      bif.stage_addr[k*WW +: WW] = 16'(k * 4);
    end
    for (int k = 0; k < 32; k++) wcnt[k] = 0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_go", 32'(bif.stage_go), 32'h0);
    check("rst_clr_n", 32'(bif.stage_clr_n), 32'hFF);
    check("rst_wr_en", 32'(bif.mem_wr_en), 32'h0);
    check("rst_mem_addr", 32'(bif.mem_addr), 32'h0);
    check("rst_busy", 32'(bif.busy), 32'h0);
    check("rst_round_done", 32'(bif.round_done), 32'h0);
    check("rst_status", 32'(bif.round_status), 32'h0);
    check("rst_last", 32'(bif.last_stage), 32'h0);
    nrst = 1'b1;
    @(posedge clk); #1;

    // Full round, all stages enabled
    run_round(8'hFF, STATUS_COMPLETE, 7, 7, "full");
    check("full_latency", launch_cyc[0] - start_cyc, 32'd3);
    for (int k = 0; k < NS - 1; k++) check("full_gap", launch_cyc[k+1] - fall_cyc[k], 32'd2);
    for (int k = 0; k < NS; k++) check("full_go_len", go_len[k], 32'd6);
    check("full_clr_pulses", clr_pulses - clr0, 32'd8);

    // Abort on stage 0 ends the round immediately
    abort_cfg = 8'h01;
    run_round(8'hFF, STATUS_ABORT, 0, 0, "abort0");
    repeat (8) @(posedge clk);
    #1;
    check("abort0_no_more_launch", 32'(bif.stage_go), 32'h0);
    abort_cfg = '0;

    // Sparse mask: stages 0 and 2 only
    run_round(8'b0000_0101, STATUS_COMPLETE, 7, 7, "mask05");
    check("mask05_gap", launch_cyc[2] - fall_cyc[0], 32'd3);
    check("mask05_go_len0", go_len[0], 32'd6);

    // Stage 3 hangs: watchdog ends the round
    dly[3] = 32'hFFFF;
    run_round(8'hFF, STATUS_TIMEOUT, 3, 3, "tmo3");
    check("tmo3_go_len", go_len[3], TO);
    @(posedge clk); #1;
    check("tmo3_wr_en_after", 32'(bif.mem_wr_en), 32'h0);
    check("tmo3_go_after", 32'(bif.stage_go), 32'h0);
    dly[3] = 5;

    // done arriving in the watchdog's last cycle wins
    dly[7] = TO - 1;
    run_round(8'h80, STATUS_COMPLETE, 7, 7, "done_vs_tmo");
    check("done_vs_tmo_go_len", go_len[7], TO);
    dly[7] = 5;

    // Abort on the last stage
    abort_cfg = 8'h80;
    run_round(8'h80, STATUS_ABORT, 7, 7, "abort7");
    abort_cfg = '0;

    // Empty mask walks every index then completes
    run_round(8'h00, STATUS_COMPLETE, 7, 7, "mask00");
    check("mask00_duration", last_rd_cyc - start_cyc, 32'd9);

    // Stage 1 writes to its region only while running
    bif.stage_wr_en = 8'h02;
    run_round(8'h03, STATUS_COMPLETE, 7, 7, "wr1");
    check("wr1_word4", wcnt[ADDR_BASE_FORWARDING[4:0]], go_len[1]);
    check("wr1_total", wtotal, 32'd6);

    // Reset asserted while stage 1 is writing
    bif.stage_mask = 8'h02;
    dly[1] = 32'hFFFF;
    exp_launch.push_back(STAGE_FORWARDING);
    bif.start = 1'b1;
    @(posedge clk); #1;
    bif.start = 1'b0;
    i = 0;
    while (!bif.stage_go[1] && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    check("rstw_go1_seen", 32'(bif.stage_go[1]), 32'd1);
    @(posedge clk); #1;
    check("rstw_writing", 32'(bif.mem_wr_en), 32'd1);
    wb = wtotal;
    #2;
    nrst = 1'b0;
    #1;
    check("rstw_wr_en", 32'(bif.mem_wr_en), 32'h0);
    check("rstw_busy", 32'(bif.busy), 32'h0);
    check("rstw_go", 32'(bif.stage_go), 32'h0);
    check("rstw_clr_n", 32'(bif.stage_clr_n), 32'hFF);
    @(posedge clk); #1;
    check("rstw_no_write", wtotal, wb);
    nrst = 1'b1;
    bif.stage_wr_en = '0;
    dly[1] = 5;
    check("rstw_launch_q_empty", 32'(exp_launch.size()), 32'd0);

    // start held high: back-to-back rounds
    for (int k = 0; k < NS; k++) dly[k] = 2;
    bif.stage_mask = 8'hFF;
    push_round(8'hFF, STATUS_COMPLETE, 7, 7);
    push_round(8'hFF, STATUS_COMPLETE, 7, 7);
    base = rounds_seen;
    clr0 = clr_pulses;
    @(posedge clk); #1;
    bif.start = 1'b1;
    wait_rounds(base + 1, 200, "held_round1");
    rd1 = last_rd_cyc;
    i = 0;
    while (!bif.busy && i < 10) begin
      @(posedge clk); #1;
      i++;
    end
    bif.start = 1'b0;
    wait_rounds(base + 2, 200, "held_round2");
    check("held_idle_gap", launch_cyc[0] - rd1, 32'd4);
    check("held_clr_pulses", clr_pulses - clr0, 32'd16);
    repeat (12) @(posedge clk);
    #1;
    check("held_no_third_round", rounds_seen, base + 2);
    check("held_busy_end", 32'(bif.busy), 32'h0);
    check("held_launch_q_empty", 32'(exp_launch.size()), 32'd0);
    check("held_round_q_empty", 32'(exp_round.size()), 32'd0);

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed still running expected finished");
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/stage_sequencer.md
# stage_sequencer

Sequences the per-node decision pipeline (sink check, forwarding check, sink-list fix, neighbor-cluster check, best search, better-neighbor search, policy, action select) over the single shared memory port. One stage runs at a time. The block replaces the combinational done-flag priority address select and the bench-driven reset toggling with a registered FSM that:
- launches each enabled stage in order,
- routes that stage's address and write enable to memory,
- ends the round early on a stage abort or a watchdog timeout.

## Interface
- NUM_STAGES, 8, number of sequenced stages (index 0 runs first)
- WORD_WIDTH, 16, memory address/data word width
- TIMEOUT, 4096, max cycles a stage may stay in RUN before forced end of round
- clock  in  1  single clock, rising edge
- nrst  in  1  asynchronous active-low reset
- start  in  1  round request (done_learnCost); level, sampled only in IDLE
- stage_mask  in  NUM_STAGES  1 = stage enabled; sampled per stage in SELECT
- stage_done  in  NUM_STAGES  per-stage done level; only bit [idx] is observed
- stage_abort  in  NUM_STAGES  per-stage early-exit flag (e.g. forAggregation, !iamForwarding); valid with done
- stage_addr  in  NUM_STAGES*WORD_WIDTH  flattened per-stage addresses; stage k at [k*WORD_WIDTH +: WORD_WIDTH]
- stage_wr_en  in  NUM_STAGES  per-stage write requests
- stage_go  out  NUM_STAGES  one-hot enable ("done_previous") to the active stage; 0 outside RUN
- stage_clr_n  out  NUM_STAGES  per-stage synchronous soft clear, active-low, one cycle
- mem_addr  out  WORD_WIDTH  shared memory address
- mem_wr_en  out  1  shared memory write enable
- busy  out  1  high in any state except IDLE
- round_done  out  1  one-cycle pulse at end of round
- round_status  out  2  00 complete, 01 aborted, 10 timeout; held until next round_done
- last_stage  out  3  index of the stage that ended the round

## Operation
- States: IDLE, SELECT, LAUNCH, RUN, FINISH. idx is a 3-bit register. wdog is a 16-bit counter.
- IDLE:
  - If start=1: idx<=0, go to SELECT.
  - If start is held high, rounds run back to back with one IDLE cycle between them.
- SELECT:
  - If stage_mask[idx]=1: go to LAUNCH.
  - Else if idx=NUM_STAGES-1: go to FINISH with status 00.
  - Else idx<=idx+1 and stay in SELECT (one cycle per skipped stage).
- LAUNCH: stage_clr_n[idx]=0 for exactly one cycle, wdog<=0, then go to RUN.
- RUN:
  - stage_go[idx]=1, mem_addr=stage_addr[idx], mem_wr_en=stage_wr_en[idx].
  - wdog increments every cycle.
  - On stage_done[idx]=1:
    - abort=1: go to FINISH with status 01.
    - Else if idx=NUM_STAGES-1: go to FINISH with status 00.
    - Else idx<=idx+1 and go to SELECT.
  - On wdog=TIMEOUT-1 with no done: go to FINISH with status 10.
- FINISH: round_done=1, round_status and last_stage updated, go to IDLE.
- Outside RUN: mem_wr_en=0, mem_addr=stage_addr[idx] (read-only hold), stage_go=0.

## Timing
- Reset values: state IDLE, idx 0, wdog 0, stage_go 0, stage_clr_n all 1, mem_wr_en 0, mem_addr 0, busy 0, round_done 0, round_status 00, last_stage 0.
- Reset mid-round clears everything asynchronously. No partial write may follow the reset edge.
- mem_addr and mem_wr_en are combinational from registered state/idx and the stage inputs (zero added latency).
- stage_go, stage_clr_n, busy, round_done and status are registered-state decodes.
- Latency from start to first stage_go: 3 cycles (IDLE, SELECT, LAUNCH).
- Stage-to-stage gap: 2 cycles (SELECT, LAUNCH), plus 1 per masked stage.
- Simultaneous events:
  - done and timeout in the same cycle: done wins.
  - done with abort on the last stage: status 01.
  - done bits of non-active stages: ignored.
- A stage whose done level is still high from a previous round is cleared by its LAUNCH stage_clr_n before RUN samples it.
- start deasserting mid-round has no effect. The round completes.
- All-zero stage_mask: SELECT walks all indices, then FINISH with status 00, last_stage 7.

## Structure
- Package seq_pkg holds:
  - the state encoding;
  - the STATUS_COMPLETE/ABORT/TIMEOUT constants;
  - STAGE_AMISINK=0 … STAGE_SELECTACTION=7 index constants;
  - the memory address-map base constants.
- Sub-module addr_wr_mux: NUM_STAGES-way select of {addr, wr_en} by idx, with wr_en gated by the run qualifier. It supersedes the existing standalone mux.

## Test plan
- Full round, mask=8'hFF, each stage done 5 cycles after go, no aborts -> stage_go walks 0..7, round_done with status 00, last_stage 7.
- Stage 0 done with abort=1 (forAggregation) -> FINISH directly, status 01, last_stage 0, stage_go[1] never asserted.
- mask=8'b0000_0101 -> only stages 0 and 2 receive go, 3-cycle gap (SELECT, SELECT, LAUNCH) between them, status 00.
- Stage 3 never asserts done, TIMEOUT=16 -> go[3] high 16 cycles, status 10, last_stage 3, mem_wr_en 0 afterwards.
- Stage 1 writes: stage_addr[1]=16'h0004, wr_en=1 -> memory word at 0x4 updated only during RUN of stage 1. nrst pulled low mid-write -> mem_wr_en 0 immediately and busy 0.
- start held high -> two consecutive round_done pulses separated by one IDLE cycle, stage_clr_n pulsed for every stage in each round.
